banked_load_store_unit: RTL

- Parametrised successor to the processor's fixed two-bank (even/odd byte) data-memory path.
- Memory-stage unit with NUM_BANKS byte-wide synchronous banks, byte/half/word loads and stores, and signed or unsigned load extension.
- Accesses that cross a bank row are split into two cycles by an FSM, which stalls the pipeline through req_ready.

---
 rtl/banked_load_store_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/banked_load_store_unit.sv
// Memory-stage load/store unit over NUM_BANKS byte-wide synchronous banks.
// Row-crossing accesses take a second (SPLIT) cycle and stall via req_ready.
module banked_load_store_unit #(
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_BANKS  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [8*NUM_BANKS-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [8*NUM_BANKS-1:0] rsp_rdata,
  output logic                   rsp_err
);

  localparam int LANE_BITS = $clog2(NUM_BANKS);
  localparam int ROW_BITS  = ADDR_WIDTH - LANE_BITS;
  localparam int ROWS      = 1 << ROW_BITS;
  localparam int DW        = 8 * NUM_BANKS;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t               state;
  logic                 ready_q;

  logic                 pend_write;
  logic                 pend_signed;
  logic [1:0]           pend_size;
  logic [LANE_BITS-1:0] pend_lane;
  logic [ROW_BITS-1:0]  pend_row;
  logic [DW-1:0]        pend_wdata;

  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic                 rsp_write_q;
  logic                 rsp_signed_q;
  logic [1:0]           rsp_size_q;
  logic [LANE_BITS-1:0] rsp_lane_q;

  logic [LANE_BITS-1:0] req_lane;
  logic [ROW_BITS-1:0]  req_row;
  int                   req_bytes;
  logic                 req_bad;
  logic                 req_cross;
  logic                 accept;

  assign req_lane  = req_addr[LANE_BITS-1:0];
  assign req_row   = req_addr[ADDR_WIDTH-1:LANE_BITS];
  assign accept    = req_valid && ready_q;
  assign req_ready = ready_q;

  always_comb begin
    req_bytes = 1 << req_size;
    req_bad   = (req_size == 2'd3) || (req_bytes > NUM_BANKS);
    req_cross = !req_bad && ((int'(req_lane) + req_bytes) > NUM_BANKS);
  end

  // Bank access: IDLE serves the incoming request (first half when crossing),
  // SPLIT serves the low lanes of the latched request on the next row.
  logic                 acc_go;
  logic [LANE_BITS-1:0] acc_lane;
  logic [ROW_BITS-1:0]  acc_row;
  int                   acc_bytes;
  logic                 acc_write;
  logic [DW-1:0]        acc_wdata;
  logic [NUM_BANKS-1:0] bank_en;
  logic [DW-1:0]        bank_wd;
  logic [DW-1:0]        bank_q;

  always_comb begin
    acc_go    = accept && !req_bad;
    acc_lane  = req_lane;
    acc_row   = req_row;
    acc_bytes = req_bytes;
    acc_write = req_write;
    acc_wdata = req_wdata;
    bank_en   = '0;
    bank_wd   = '0;
    if (state == SPLIT) begin
      acc_go    = 1'b1;
      acc_lane  = pend_lane;
      acc_row   = pend_row + ROW_BITS'(1);
      acc_bytes = 1 << pend_size;
      acc_write = pend_write;
      acc_wdata = pend_wdata;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_wd[8*b +: 8] = acc_wdata[8*((b - int'(acc_lane) + NUM_BANKS) % NUM_BANKS) +: 8];
      if (state == SPLIT)
        bank_en[b] = acc_go && ((b + NUM_BANKS) < (int'(acc_lane) + acc_bytes));
      else
        bank_en[b] = acc_go && (b >= int'(acc_lane)) && ((b - int'(acc_lane)) < acc_bytes);
    end
  end

  // Disabled lanes hold their last read, which keeps first-half bytes of a
  // split load in place while the second half is fetched.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [7:0] mem [ROWS];
    logic [7:0] q;
    always_ff @(posedge clk) begin
      if (bank_en[g]) begin
        if (acc_write) mem[acc_row] <= bank_wd[8*g +: 8];
        q <= mem[acc_row];
      end
    end
    assign bank_q[8*g +: 8] = q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ready_q      <= 1'b0;
      pend_write   <= 1'b0;
      pend_signed  <= 1'b0;
      pend_size    <= '0;
      pend_lane    <= '0;
      pend_row     <= '0;
      pend_wdata   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_signed_q <= 1'b0;
      rsp_size_q   <= '0;
      rsp_lane_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (req_cross) begin
              state       <= SPLIT;
              ready_q     <= 1'b0;
              pend_write  <= req_write;
              pend_signed <= req_signed;
              pend_size   <= req_size;
              pend_lane   <= req_lane;
              pend_row    <= req_row;
              pend_wdata  <= req_wdata;
            end else begin
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= req_bad;
              rsp_write_q  <= req_write;
              rsp_signed_q <= req_signed;
              rsp_size_q   <= req_size;
              rsp_lane_q   <= req_lane;
            end
          end
        end
        SPLIT: begin
          state        <= IDLE;
          ready_q      <= 1'b1;
          rsp_valid_q  <= 1'b1;
          rsp_write_q  <= pend_write;
          rsp_signed_q <= pend_signed;
          rsp_size_q   <= pend_size;
          rsp_lane_q   <= pend_lane;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Rotate bank outputs so the byte at the request address lands in bits [7:0].
  logic [DW-1:0] merged;
  logic [DW-1:0] ext;
  logic          sign;
  int            rsp_bytes;

  always_comb begin
    merged    = '0;
    ext       = '0;
    sign      = 1'b0;
    rsp_bytes = 1 << rsp_size_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      merged[8*i +: 8] = bank_q[8*((i + int'(rsp_lane_q)) % NUM_BANKS) +: 8];
      if (i == rsp_bytes - 1) sign = merged[8*i+7];
    end
    for (int i = 0; i < NUM_BANKS; i++)
      ext[8*i +: 8] = (i < rsp_bytes) ? merged[8*i +: 8] : {8{rsp_signed_q & sign}};
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && !rsp_err_q && !rsp_write_q) ? ext : '0;

endmodule
